// File: rtl/processor_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: state codes, instruction
// classes, and the PC/INC/Y mux select values.
package processor_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StMemory    = 3'd4,
        StWriteback = 3'd5,
        StHalt      = 3'd6,
        StFault     = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu    = 3'd0,
        ClsLoad   = 3'd1,
        ClsStore  = 3'd2,
        ClsBranch = 3'd3,
        ClsCall   = 3'd4,
        ClsHalt   = 3'd5,
        ClsIll6   = 3'd6,
        ClsIll7   = 3'd7
    } inst_class_e;

    localparam logic [1:0] Y_RZ  = 2'd0;
    localparam logic [1:0] Y_MEM = 2'd1;
    localparam logic [1:0] Y_RET = 2'd2;

    localparam logic PC_SEL_RA   = 1'b0;
    localparam logic PC_SEL_INC  = 1'b1;
    localparam logic INC_SEL_ONE = 1'b0;
    localparam logic INC_SEL_OFS = 1'b1;

    function automatic logic is_illegal(inst_class_e cls);
        return (cls == ClsIll6) || (cls == ClsIll7);
    endfunction

endpackage

// File: rtl/mfc_watchdog.sv
// Counts cycles spent waiting for MFC and flags the cycle in which the wait
// limit is reached without MFC.
module mfc_watchdog #(
    parameter int unsigned MFC_TIMEOUT = 15,
    parameter int unsigned TMO_WIDTH   = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_i,
    output logic expire_o
);

    // Expiry fires in the wait cycle that would bring the count to MFC_TIMEOUT.
    localparam logic [TMO_WIDTH-1:0] Limit = TMO_WIDTH'(MFC_TIMEOUT - 1);

    logic [TMO_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = count_i && (cnt_q == Limit);

endmodule

// File: rtl/control_sequencer.sv
// Multicycle control unit: steps one instruction through FETCH..WRITEBACK,
// stalling on the MFC handshake and parking in HALT or FAULT until reset.
module control_sequencer
    import processor_ctrl_pkg::*;
#(
    parameter int unsigned MFC_TIMEOUT = 15,
    parameter int unsigned TMO_WIDTH   = 8
) (
    input  logic       Clock,
    input  logic       Reset_L,
    input  logic       Run,
    input  logic       MFC,
    input  logic [2:0] InstClass,
    input  logic       WritesReg,
    input  logic       BranchTaken,
    output logic       IR_Enable,
    output logic       PC_Enable,
    output logic       RA_Enable,
    output logic       RB_Enable,
    output logic       RZ_Enable,
    output logic       RM_Enable,
    output logic       RY_Enable,
    output logic       CCR_Enable,
    output logic       RF_WRITE,
    output logic       PC_Select,
    output logic       INC_Select,
    output logic [1:0] Y_Select,
    output logic       MEM_Read,
    output logic       MEM_Write,
    output logic       OperationFinished,
    output logic       Halted,
    output logic       Fault,
    output logic [2:0] StepCount
);

    state_e      state_q, state_d;
    inst_class_e cls;
    logic        waiting;
    logic        expire;

    assign cls     = inst_class_e'(InstClass);
    assign waiting = (state_q == StFetch) ||
                     ((state_q == StMemory) && ((cls == ClsLoad) || (cls == ClsStore)));

    mfc_watchdog #(
        .MFC_TIMEOUT(MFC_TIMEOUT),
        .TMO_WIDTH  (TMO_WIDTH)
    ) u_mfc_watchdog (
        .clk_i   (Clock),
        .rst_ni  (Reset_L),
        .clear_i (!waiting),
        .count_i (waiting && !MFC),
        .expire_o(expire)
    );

    always_ff @(posedge Clock) begin
        if (!Reset_L) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        IR_Enable         = 1'b0;
        PC_Enable         = 1'b0;
        RA_Enable         = 1'b0;
        RB_Enable         = 1'b0;
        RZ_Enable         = 1'b0;
        RM_Enable         = 1'b0;
        RY_Enable         = 1'b0;
        CCR_Enable        = 1'b0;
        RF_WRITE          = 1'b0;
        PC_Select         = PC_SEL_INC;
        INC_Select        = INC_SEL_ONE;
        Y_Select          = Y_RZ;
        MEM_Read          = 1'b0;
        MEM_Write         = 1'b0;
        OperationFinished = 1'b0;

        // Strobes are suppressed while reset is held so an abandoned access never fires.
        if (Reset_L) begin
            unique case (state_q)
                StIdle: begin
                    if (Run) state_d = StFetch;
                end
                StFetch: begin
                    MEM_Read = 1'b1;
                    if (MFC) begin
                        IR_Enable = 1'b1;
                        PC_Enable = 1'b1;
                        state_d   = StDecode;
                    end else if (expire) begin
                        state_d = StFault;
                    end
                end
                StDecode: begin
                    RA_Enable = 1'b1;
                    RB_Enable = 1'b1;
                    if (is_illegal(cls))     state_d = StFault;
                    else if (cls == ClsHalt) state_d = StHalt;
                    else                     state_d = StExecute;
                end
                StExecute: begin
                    RZ_Enable = 1'b1;
                    RM_Enable = 1'b1;
                    state_d   = StMemory;
                    case (cls)
                        ClsAlu: CCR_Enable = 1'b1;
                        ClsBranch: begin
                            if (BranchTaken) begin
                                PC_Enable  = 1'b1;
                                INC_Select = INC_SEL_OFS;
                            end
                        end
                        ClsCall: begin
                            PC_Enable = 1'b1;
                            PC_Select = PC_SEL_RA;
                        end
                        default: ;
                    endcase
                end
                StMemory: begin
                    case (cls)
                        ClsLoad: begin
                            MEM_Read = 1'b1;
                            if (MFC) begin
                                RY_Enable = 1'b1;
                                Y_Select  = Y_MEM;
                                state_d   = StWriteback;
                            end else if (expire) begin
                                state_d = StFault;
                            end
                        end
                        ClsStore: begin
                            MEM_Write = 1'b1;
                            if (MFC)         state_d = StWriteback;
                            else if (expire) state_d = StFault;
                        end
                        ClsCall: begin
                            RY_Enable = 1'b1;
                            Y_Select  = Y_RET;
                            state_d   = StWriteback;
                        end
                        default: begin
                            RY_Enable = 1'b1;
                            state_d   = StWriteback;
                        end
                    endcase
                end
                StWriteback: begin
                    RF_WRITE          = WritesReg && (cls != ClsStore) && (cls != ClsBranch);
                    OperationFinished = 1'b1;
                    state_d           = Run ? StFetch : StIdle;
                end
                StHalt:  ;
                StFault: ;
                default: state_d = StIdle;
            endcase
        end
    end

    assign Halted    = (state_q == StHalt);
    assign Fault     = (state_q == StFault);
    assign StepCount = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven, scoreboarded bench for control_sequencer: one vector per clock,
// expected outputs queued on drive and compared before the next rising edge.
module tb_control_sequencer;

    localparam int unsigned Timeout = 15;

    logic       Clock = 1'b0;
    logic       Reset_L, Run, MFC, WritesReg, BranchTaken;
    logic [2:0] InstClass;
    logic       IR_Enable, PC_Enable, RA_Enable, RB_Enable, RZ_Enable, RM_Enable;
    logic       RY_Enable, CCR_Enable, RF_WRITE, PC_Select, INC_Select;
    logic [1:0] Y_Select;
    logic       MEM_Read, MEM_Write, OperationFinished, Halted, Fault;
    logic [2:0] StepCount;

    always #5 Clock = ~Clock;

    control_sequencer #(
        .MFC_TIMEOUT(Timeout),
        .TMO_WIDTH  (8)
    ) dut (
        .Clock            (Clock),
        .Reset_L          (Reset_L),
        .Run              (Run),
        .MFC              (MFC),
        .InstClass        (InstClass),
        .WritesReg        (WritesReg),
        .BranchTaken      (BranchTaken),
        .IR_Enable        (IR_Enable),
        .PC_Enable        (PC_Enable),
        .RA_Enable        (RA_Enable),
        .RB_Enable        (RB_Enable),
        .RZ_Enable        (RZ_Enable),
        .RM_Enable        (RM_Enable),
        .RY_Enable        (RY_Enable),
        .CCR_Enable       (CCR_Enable),
        .RF_WRITE         (RF_WRITE),
        .PC_Select        (PC_Select),
        .INC_Select       (INC_Select),
        .Y_Select         (Y_Select),
        .MEM_Read         (MEM_Read),
        .MEM_Write        (MEM_Write),
        .OperationFinished(OperationFinished),
        .Halted           (Halted),
        .Fault            (Fault),
        .StepCount        (StepCount)
    );

    // Output bundle: {IR,PC,RA,RB,RZ,RM,RY,CCR,RFW,MR,MW,OF,HALTED,FAULT,PCSEL,INCSEL,Y[1:0],STEP[2:0]}
    logic [20:0] act;
    assign act = {IR_Enable, PC_Enable, RA_Enable, RB_Enable, RZ_Enable, RM_Enable,
                  RY_Enable, CCR_Enable, RF_WRITE, MEM_Read, MEM_Write, OperationFinished,
                  Halted, Fault, PC_Select, INC_Select, Y_Select, StepCount};

    localparam logic [20:0] B_IR  = 21'd1 << 20;
    localparam logic [20:0] B_PC  = 21'd1 << 19;
    localparam logic [20:0] B_RA  = 21'd1 << 18;
    localparam logic [20:0] B_RB  = 21'd1 << 17;
    localparam logic [20:0] B_RZ  = 21'd1 << 16;
    localparam logic [20:0] B_RM  = 21'd1 << 15;
    localparam logic [20:0] B_RY  = 21'd1 << 14;
    localparam logic [20:0] B_CCR = 21'd1 << 13;
    localparam logic [20:0] B_RFW = 21'd1 << 12;
    localparam logic [20:0] B_MR  = 21'd1 << 11;
    localparam logic [20:0] B_MW  = 21'd1 << 10;
    localparam logic [20:0] B_OF  = 21'd1 << 9;
    localparam logic [20:0] B_HLT = 21'd1 << 8;
    localparam logic [20:0] B_FLT = 21'd1 << 7;
    localparam logic [20:0] B_PCS = 21'd1 << 6;
    localparam logic [20:0] B_INC = 21'd1 << 5;
    localparam logic [20:0] B_Y1  = 21'd1 << 3;
    localparam logic [20:0] B_Y2  = 21'd2 << 3;
    localparam logic [20:0] D     = B_PCS;  // PC_Select idles at 1

    localparam logic [2:0] ALU = 3'd0, LD = 3'd1, ST = 3'd2, BR = 3'd3, CALL = 3'd4,
                           HLT = 3'd5, ILL = 3'd6;

    typedef struct {
        string       name;
        logic        rst_l, run, mfc;
        logic [2:0]  cls;
        logic        wr, br;
        logic [20:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [20:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(string name, logic rst_l, logic run, logic mfc,
                                logic [2:0] cls, logic wr, logic br, logic [20:0] exp);
        vec_t v;
        v.name = name; v.rst_l = rst_l; v.run = run; v.mfc = mfc;
        v.cls = cls; v.wr = wr; v.br = br; v.exp = exp;
        return v;
    endfunction

    function automatic void add(string name, logic rst_l, logic run, logic mfc,
                                logic [2:0] cls, logic wr, logic br, logic [20:0] exp);
        tbl.push_back(mk(name, rst_l, run, mfc, cls, wr, br, exp));
    endfunction

    task automatic check();
        sb_t e;
        e = sb.pop_front();
        n_checks++;
        if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
        end
    endtask

    task automatic apply(input vec_t v);
        sb_t e;
        @(negedge Clock);
        Reset_L = v.rst_l; Run = v.run; MFC = v.mfc;
        InstClass = v.cls; WritesReg = v.wr; BranchTaken = v.br;
        e.name = v.name;
        e.exp  = v.exp;
        sb.push_back(e);
        #1 check();
    endtask

    initial begin
        Reset_L = 1'b0; Run = 1'b0; MFC = 1'b0;
        InstClass = ALU; WritesReg = 1'b0; BranchTaken = 1'b0;
        repeat (2) @(posedge Clock);

        add("reset",      0, 0, 0, ALU, 0, 0, D | 21'd0);
        add("idle_hold",  1, 0, 0, ALU, 0, 0, D | 21'd0);
        add("idle_go",    1, 1, 0, ALU, 0, 0, D | 21'd0);
        // ALU, zero-wait fetch
        add("alu_f",  1, 1, 1, ALU, 1, 0, D | B_IR | B_PC | B_MR | 21'd1);
        add("alu_d",  1, 1, 0, ALU, 1, 0, D | B_RA | B_RB | 21'd2);
        add("alu_e",  1, 1, 0, ALU, 1, 0, D | B_RZ | B_RM | B_CCR | 21'd3);
        add("alu_m",  1, 1, 0, ALU, 1, 0, D | B_RY | 21'd4);
        add("alu_wb", 1, 1, 0, ALU, 1, 0, D | B_RFW | B_OF | 21'd5);
        // LOAD, MFC delayed three cycles in MEMORY
        add("ld_f",   1, 1, 1, LD, 1, 0, D | B_IR | B_PC | B_MR | 21'd1);
        add("ld_d",   1, 1, 0, LD, 1, 0, D | B_RA | B_RB | 21'd2);
        add("ld_e",   1, 1, 0, LD, 1, 0, D | B_RZ | B_RM | 21'd3);
        for (int i = 0; i < 3; i++) add("ld_mwait", 1, 1, 0, LD, 1, 0, D | B_MR | 21'd4);
        add("ld_mfc", 1, 1, 1, LD, 1, 0, D | B_MR | B_RY | B_Y1 | 21'd4);
        add("ld_wb",  1, 1, 0, LD, 1, 0, D | B_RFW | B_OF | 21'd5);
        // BRANCH taken
        add("brt_f",  1, 1, 1, BR, 1, 1, D | B_IR | B_PC | B_MR | 21'd1);
        add("brt_d",  1, 1, 0, BR, 1, 1, D | B_RA | B_RB | 21'd2);
        add("brt_e",  1, 1, 0, BR, 1, 1, D | B_RZ | B_RM | B_PC | B_INC | 21'd3);
        add("brt_m",  1, 1, 0, BR, 1, 1, D | B_RY | 21'd4);
        add("brt_wb", 1, 1, 0, BR, 1, 1, D | B_OF | 21'd5);
        // BRANCH not taken; Run drops mid-instruction and returns by WRITEBACK
        add("brn_f",  1, 1, 1, BR, 1, 0, D | B_IR | B_PC | B_MR | 21'd1);
        add("brn_d",  1, 0, 0, BR, 1, 0, D | B_RA | B_RB | 21'd2);
        add("brn_e",  1, 0, 0, BR, 1, 0, D | B_RZ | B_RM | 21'd3);
        add("brn_m",  1, 0, 0, BR, 1, 0, D | B_RY | 21'd4);
        add("brn_wb", 1, 1, 0, BR, 1, 0, D | B_OF | 21'd5);
        // CALL: jump to RA, return address into RY
        add("call_f",  1, 1, 1, CALL, 1, 0, D | B_IR | B_PC | B_MR | 21'd1);
        add("call_d",  1, 1, 0, CALL, 1, 0, D | B_RA | B_RB | 21'd2);
        add("call_e",  1, 1, 0, CALL, 1, 0, B_RZ | B_RM | B_PC | 21'd3);
        add("call_m",  1, 1, 0, CALL, 1, 0, D | B_RY | B_Y2 | 21'd4);
        add("call_wb", 1, 1, 0, CALL, 1, 0, D | B_RFW | B_OF | 21'd5);
        // STORE aborted by reset in MEMORY, then a full STORE with Run dropping
        add("st_f",     1, 1, 1, ST, 1, 0, D | B_IR | B_PC | B_MR | 21'd1);
        add("st_d",     1, 1, 0, ST, 1, 0, D | B_RA | B_RB | 21'd2);
        add("st_e",     1, 1, 0, ST, 1, 0, D | B_RZ | B_RM | 21'd3);
        add("st_mwait", 1, 1, 0, ST, 1, 0, D | B_MW | 21'd4);
        add("st_rst",   0, 1, 1, ST, 1, 0, D | 21'd4);
        add("st_idle",  1, 1, 0, ST, 1, 0, D | 21'd0);
        add("st2_f",    1, 1, 1, ST, 1, 0, D | B_IR | B_PC | B_MR | 21'd1);
        add("st2_d",    1, 1, 0, ST, 1, 0, D | B_RA | B_RB | 21'd2);
        add("st2_e",    1, 1, 0, ST, 1, 0, D | B_RZ | B_RM | 21'd3);
        add("st2_m",    1, 1, 1, ST, 1, 0, D | B_MW | 21'd4);
        add("st2_wb",   1, 0, 0, ST, 1, 0, D | B_OF | 21'd5);
        add("st2_idle", 1, 0, 0, ST, 1, 0, D | 21'd0);
        // Illegal class faults after DECODE
        add("ill_go",   1, 1, 0, ILL, 0, 0, D | 21'd0);
        add("ill_f",    1, 1, 1, ILL, 0, 0, D | B_IR | B_PC | B_MR | 21'd1);
        add("ill_d",    1, 1, 1, ILL, 0, 0, D | B_RA | B_RB | 21'd2);
        add("ill_flt",  1, 1, 1, ILL, 0, 0, D | B_FLT | 21'd7);
        add("ill_flt2", 1, 0, 1, ILL, 0, 0, D | B_FLT | 21'd7);
        add("ill_rst",  0, 0, 0, ILL, 0, 0, D | B_FLT | 21'd7);
        add("ill_idle", 1, 0, 0, ILL, 0, 0, D | 21'd0);
        // HALT parks regardless of Run
        add("hlt_go",   1, 1, 0, HLT, 0, 0, D | 21'd0);
        add("hlt_f",    1, 1, 1, HLT, 0, 0, D | B_IR | B_PC | B_MR | 21'd1);
        add("hlt_d",    1, 1, 0, HLT, 0, 0, D | B_RA | B_RB | 21'd2);
        add("hlt_s0",   1, 0, 1, HLT, 0, 0, D | B_HLT | 21'd6);
        add("hlt_s1",   1, 1, 1, HLT, 0, 0, D | B_HLT | 21'd6);
        add("hlt_s2",   1, 0, 0, ALU, 0, 0, D | B_HLT | 21'd6);
        add("hlt_rst",  0, 0, 0, ALU, 0, 0, D | B_HLT | 21'd6);
        add("hlt_idle", 1, 0, 0, ALU, 0, 0, D | 21'd0);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // MFC never arrives in FETCH: MEM_Read for Timeout cycles, then FAULT.
        apply(mk("tmo_go", 1, 1, 0, ALU, 0, 0, D | 21'd0));
        for (int i = 0; i < Timeout; i++) apply(mk("tmo_wait", 1, 1, 0, ALU, 0, 0, D | B_MR | 21'd1));
        for (int i = 0; i < 3; i++) apply(mk("tmo_fault", 1, 1, i[0], ALU, 0, 0, D | B_FLT | 21'd7));
        apply(mk("tmo_rst",  0, 0, 0, ALU, 0, 0, D | B_FLT | 21'd7));
        apply(mk("tmo_idle", 1, 0, 0, ALU, 0, 0, D | 21'd0));

        // MFC on the final allowed wait cycle wins over expiry.
        apply(mk("late_go", 1, 1, 0, ALU, 0, 0, D | 21'd0));
        for (int i = 0; i < Timeout - 1; i++) apply(mk("late_wait", 1, 1, 0, ALU, 0, 0, D | B_MR | 21'd1));
        apply(mk("late_mfc", 1, 1, 1, ALU, 0, 0, D | B_IR | B_PC | B_MR | 21'd1));
        apply(mk("late_d",   1, 1, 0, ALU, 0, 0, D | B_RA | B_RB | 21'd2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
